// File: rtl/result_pkg.sv
// rtl/result_pkg.sv - shared constants and state type for the result collector
package result_pkg;
    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 64;
    localparam int SUM_W_DEF = 12;
    localparam int PIX_W     = 8;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/result_clip.sv
// rtl/result_clip.sv - signed filter sum to 8-bit pixel; RESULT_COLLECTOR_CLIP_EN selects clamping over truncation
module result_clip
    import result_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic signed [SUM_W-1:0] sum_i,
    output logic [PIX_W-1:0]        pix_o
);

`ifdef RESULT_COLLECTOR_CLIP_EN
    // Sign bit flags negatives; any set magnitude bit above bit 7 means > 255.
    always_comb begin
        if (sum_i[SUM_W-1]) begin
            pix_o = '0;
        end else if (|sum_i[SUM_W-2:PIX_W]) begin
            pix_o = '1;
        end else begin
            pix_o = sum_i[PIX_W-1:0];
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^sum_i[SUM_W-1:PIX_W];
    assign pix_o     = sum_i[PIX_W-1:0];
`endif

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - frame buffer that fills from a filter stream and drains on request (RESULT_COLLECTOR_CLIP_EN)
module result_collector
    import result_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [SUM_W-1:0] in_data,
    output logic                    in_ready,
    output logic                    frame_done,
    input  logic                    out_req,
    output logic                    out_valid,
    output logic [PIX_W-1:0]        out_data,
    input  logic                    out_ready
);

    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [PIX_W-1:0] mem [DEPTH];

    state_e           state_q;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [AW-1:0]    raddr_q, raddr_d;
    logic             out_valid_q;
    logic             frame_done_q;
    logic [PIX_W-1:0] out_data_q;
    logic [PIX_W-1:0] pix;
    logic             wr_en;

    result_clip #(.SUM_W(SUM_W)) u_clip (
        .sum_i (in_data),
        .pix_o (pix)
    );

    assign waddr_d    = waddr_q + 1'b1;
    assign raddr_d    = raddr_q + 1'b1;
    assign wr_en      = (state_q == FILL) && in_valid && !rst;
    assign in_ready   = (state_q == FILL);
    assign frame_done = frame_done_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    // Buffer has no reset so a reset never disturbs stored pixels.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr_q] <= pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            waddr_q      <= '0;
            raddr_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        if (waddr_q == LAST) begin
                            frame_done_q <= 1'b1;
                            waddr_q      <= '0;
                            state_q      <= FULL;
                        end else begin
                            waddr_q <= waddr_d;
                        end
                    end
                end
                FULL: begin
                    if (out_req) begin
                        state_q <= DRAIN;
                        raddr_q <= '0;
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle loads pixel 0; later ones advance on handshake.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= mem[raddr_q];
                    end else if (out_ready) begin
                        if (raddr_q == LAST) begin
                            out_valid_q <= 1'b0;
                            raddr_q     <= '0;
                            state_q     <= FILL;
                        end else begin
                            raddr_q    <= raddr_d;
                            out_data_q <= mem[raddr_d];
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule
